// File: rtl/sram_lsu.sv
// rtl/sram_lsu.sv - byte/half/word load-store unit in front of a word-organised sram
// One request at a time; sub-word stores do read-modify-write on big-endian lanes.
module sram_lsu #(
    parameter int AWIDTH = 8,
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DWIDTH-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_cs,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_din,
    input  logic [DWIDTH-1:0] mem_dout
);

    generate
        if (DWIDTH != 32) begin : g_bad_dwidth
            $error("sram_lsu: DWIDTH must be 32");
        end
        if (DEPTH != (1 << (AWIDTH - 2))) begin : g_bad_depth
            $error("sram_lsu: DEPTH must equal 2**(AWIDTH-2)");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        READ,
        RWAIT,
        WRITE,
        RESP
    } state_t;

    state_t state, next_state;

    logic [AWIDTH-1:0] addr_q;
    logic [1:0]        size_q;
    logic              we_q;
    logic              signed_q;
    logic              err_q;
    logic [DWIDTH-1:0] wdata_q;
    logic [DWIDTH-1:0] word_q;
    logic [DWIDTH-1:0] rdata_q;

    logic              accept;
    logic              req_err;
    logic [7:0]        lane8;
    logic [15:0]       lane16;
    logic [DWIDTH-1:0] load_val;
    logic [DWIDTH-1:0] merge_val;

    assign accept  = req_valid && (state == IDLE);
    assign req_err = (req_size == 2'b11)
                  || ((req_size == 2'b01) && req_addr[0])
                  || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)
                        next_state = RESP;
                    else if (req_we && (req_size == 2'b10))
                        next_state = WRITE;
                    else
                        next_state = READ;
                end
            end
            READ:    next_state = RWAIT;
            RWAIT:   next_state = we_q ? WRITE : RESP;
            WRITE:   next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Lane extraction and merge work off the sram word captured in RWAIT.
    always_comb begin
        lane8     = 8'h00;
        lane16    = 16'h0000;
        load_val  = mem_dout;
        merge_val = mem_dout;
        case (size_q)
            2'b00: begin
                case (addr_q[1:0])
                    2'd0: begin lane8 = mem_dout[31:24]; merge_val[31:24] = wdata_q[7:0]; end
                    2'd1: begin lane8 = mem_dout[23:16]; merge_val[23:16] = wdata_q[7:0]; end
                    2'd2: begin lane8 = mem_dout[15:8];  merge_val[15:8]  = wdata_q[7:0]; end
                    default: begin lane8 = mem_dout[7:0]; merge_val[7:0] = wdata_q[7:0]; end
                endcase
                load_val = signed_q ? {{24{lane8[7]}}, lane8} : {24'h000000, lane8};
            end
            2'b01: begin
                if (addr_q[1]) begin
                    lane16          = mem_dout[15:0];
                    merge_val[15:0] = wdata_q[15:0];
                end else begin
                    lane16           = mem_dout[31:16];
                    merge_val[31:16] = wdata_q[15:0];
                end
                load_val = signed_q ? {{16{lane16[15]}}, lane16} : {16'h0000, lane16};
            end
            default: begin
                load_val  = mem_dout;
                merge_val = wdata_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            size_q   <= 2'b00;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            word_q   <= '0;
            rdata_q  <= '0;
        end else if (accept) begin
            addr_q   <= req_addr;
            size_q   <= req_size;
            we_q     <= req_we;
            signed_q <= req_signed;
            err_q    <= req_err;
            wdata_q  <= req_wdata;
            word_q   <= req_wdata;
            rdata_q  <= '0;
        end else if (state == RWAIT) begin
            if (we_q)
                word_q <= merge_val;
            else
                rdata_q <= load_val;
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_err   = (state == RESP) && err_q;
    assign resp_rdata = (state == RESP) ? rdata_q : '0;
    assign mem_rd     = (state == READ);
    assign mem_wr     = (state == WRITE);
    assign mem_cs     = (state == READ) || (state == WRITE);
    assign mem_addr   = {addr_q[AWIDTH-1:2], 2'b00};
    assign mem_din    = word_q;

endmodule

// File: tb/tb_sram_lsu.sv
// tb/tb_sram_lsu.sv - scoreboard bench for sram_lsu with an sram model and reference memory
module tb_sram_lsu;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_cs;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    sram_lsu #(.AWIDTH(8), .DWIDTH(32), .DEPTH(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_cs     (mem_cs),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
        logic [7:0]  addr;
        logic [31:0] wword;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] sram[64];
    logic [31:0] ref_mem[64];
    int          cyc = 0;
    int          total = 0;
    int          passed = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_cs && mem_rd) mem_dout <= sram[mem_addr[7:2]];
        if (mem_cs && mem_wr) sram[mem_addr[7:2]] <= mem_din;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            rd_cnt = 0;
            wr_cnt = 0;
        end else begin
            if (mem_rd && mem_wr) check("rd_wr_overlap", 1, 0);
            if (mem_cs !== (mem_rd | mem_wr)) check("cs_iff_strobe", {31'b0, mem_cs}, {31'b0, mem_rd | mem_wr});
            if (exp_q.size() > 0 && cyc >= exp_q[0].acc) check("ready_low_busy", {31'b0, req_ready}, 0);
            if (mem_rd || mem_wr) begin
                if (exp_q.size() == 0) check("unexpected_strobe", 1, 0);
                else begin
                    check("mem_addr", {24'b0, mem_addr}, {24'b0, exp_q[0].addr});
                    if (mem_wr) check("mem_din", mem_din, exp_q[0].wword);
                end
                if (mem_rd) rd_cnt++;
                if (mem_wr) wr_cnt++;
            end
            if (resp_valid) begin
                if (exp_q.size() == 0) check("spurious_resp", 1, 0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
                    check("latency", cyc - e.acc + 1, e.lat);
                    check("rd_count", rd_cnt, e.nrd);
                    check("wr_count", wr_cnt, e.nwr);
                end
                rd_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    function automatic exp_t model(input logic we, input logic [1:0] size, input logic sgn,
                                   input logic [7:0] addr, input logic [31:0] wdata);
        exp_t        e;
        logic [31:0] word, mask, v;
        int          sh;
        word    = ref_mem[addr[7:2]];
        e.addr  = {addr[7:2], 2'b00};
        e.err   = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
        e.rdata = 32'h0;
        e.wword = 32'h0;
        e.acc   = 0;
        sh      = (size == 2'd0) ? 8 * (3 - int'(addr[1:0])) : 16 * (1 - int'(addr[1]));
        mask    = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
        if (e.err) begin
            e.lat = 1; e.nrd = 0; e.nwr = 0;
        end else if (we) begin
            e.nwr = 1;
            if (size == 2'd2) begin
                e.wword = wdata; e.lat = 2; e.nrd = 0;
            end else begin
                e.wword = (word & ~mask) | ((wdata << sh) & mask);
                e.lat = 4; e.nrd = 1;
            end
        end else begin
            e.lat = 3; e.nrd = 1; e.nwr = 0;
            if (size == 2'd2) v = word;
            else v = (word & mask) >> sh;
            if (sgn && size == 2'd0 && v[7])  v = v | 32'hFFFFFF00;
            if (sgn && size == 2'd1 && v[15]) v = v | 32'hFFFF0000;
            e.rdata = v;
        end
        return e;
    endfunction

    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [7:0] addr, input logic [31:0] wdata, input bit commit);
        exp_t e;
        int   n;
        e = model(we, size, sgn, addr, wdata);
        if (commit && we && !e.err) ref_mem[addr[7:2]] = e.wword;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("ready_timeout", 0, 1);
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        e.acc      = cyc + 1;
        exp_q.push_back(e);
        @(negedge clk);
        // junk presented while busy must be ignored
        req_valid  = 1'($urandom_range(0, 1));
        req_we     = 1'($urandom_range(0, 1));
        req_size   = 2'($urandom_range(0, 3));
        req_addr   = 8'($urandom);
        req_wdata  = $urandom;
    endtask

    task automatic idle_out;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 8'h00; req_wdata = 32'h0;
        for (int i = 0; i < 64; i++) begin
            sram[i]    = $urandom;
            ref_mem[i] = sram[i];
        end
        #2;
        check("rst_ready", {31'b0, req_ready}, 1);
        check("rst_resp_valid", {31'b0, resp_valid}, 0);
        check("rst_resp_err", {31'b0, resp_err}, 0);
        check("rst_cs", {31'b0, mem_cs}, 0);
        check("rst_addr", {24'b0, mem_addr}, 0);
        check("rst_din", mem_din, 0);
        check("rst_rdata", resp_rdata, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(1, 2'd2, 0, 8'h5C, 32'h5800FEA9, 1); idle_out();
        issue(0, 2'd2, 0, 8'h5C, 32'h0, 1);        idle_out();
        issue(1, 2'd0, 0, 8'h5D, 32'h000000A5, 1); idle_out();
        issue(0, 2'd0, 1, 8'h5D, 32'h0, 1);        idle_out();
        issue(0, 2'd0, 0, 8'h5D, 32'h0, 1);        idle_out();
        issue(0, 2'd1, 1, 8'h5E, 32'h0, 1);        idle_out();
        issue(0, 2'd1, 0, 8'h5E, 32'h0, 1);        idle_out();
        issue(0, 2'd2, 0, 8'h5E, 32'h0, 1);        idle_out();
        issue(1, 2'd1, 0, 8'h5F, 32'h1234, 1);     idle_out();
        issue(0, 2'd3, 0, 8'h5C, 32'h0, 1);        idle_out();
        issue(1, 2'd1, 0, 8'h5E, 32'hCAFE8001, 1); idle_out();
        issue(0, 2'd2, 0, 8'h5C, 32'h0, 1);        idle_out();

        issue(1, 2'd0, 0, 8'hFC, 32'h0000003C, 0);
        idle_out();
        n = 0;
        while (!mem_wr && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("saw_write_before_reset", {31'b0, mem_wr}, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_wr_drop", {31'b0, mem_wr}, 0);
        check("async_cs_drop", {31'b0, mem_cs}, 0);
        check("async_ready", {31'b0, req_ready}, 1);
        check("async_din_clear", mem_din, 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        issue(0, 2'd2, 0, 8'hFC, 32'h0, 1); idle_out();

        for (int i = 0; i < 150; i++) begin
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  8'($urandom), $urandom, 1);
            idle_out();
        end

        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
        for (int i = 0; i < 64; i++) begin
            if (sram[i] !== ref_mem[i]) check("final_mem", sram[i], ref_mem[i]);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
